// File: rtl/mvm_param.sv
// rtl/mvm_param.sv - parametrised matrix-vector multiplier with load stalls and output backpressure
module mvm_param #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int LANES    = 1,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadMatrix,
    input  logic             loadVector,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  data_in,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out
);

    // Derived sizes; every index is at least one bit wide so degenerate shapes still elaborate
    localparam int PASSES = ROWS / LANES;
    localparam int NA     = ROWS * COLS;
    localparam int AW     = (NA > 1)     ? $clog2(NA)     : 1;
    localparam int CW     = (COLS > 1)   ? $clog2(COLS)   : 1;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int RW     = (ROWS > 1)   ? $clog2(ROWS)   : 1;
    localparam int PROD_W = 2 * IN_W;
    localparam int ACC_W  = 2 * IN_W + $clog2(COLS);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_A  = 3'd1;
    localparam logic [2:0] S_LOAD_X  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    // Control state
    logic [2:0]       state_q,     state_d;
    logic [AW-1:0]    ld_idx_q,    ld_idx_d;
    logic [CW-1:0]    col_q,       col_d;
    logic [PW-1:0]    pass_q,      pass_d;
    logic             fin_q,       fin_d;
    logic [RW-1:0]    oidx_q,      oidx_d;
    logic             done_q,      done_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] data_out_q,  data_out_d;

    // Per-lane full-precision accumulators
    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;

    // Operand and result storage (not reset: contents are only meaningful once loaded)
    logic signed [IN_W-1:0] a_mem_q [NA];
    logic signed [IN_W-1:0] x_mem_q [COLS];
    logic [OUT_W-1:0]       y_mem_q [ROWS];

    logic             a_we;
    logic             x_we;
    logic             y_we;
    logic [RW-1:0]    y_waddr [LANES];
    logic [OUT_W-1:0] y_wdata [LANES];

    // Narrow a full-precision sum to OUT_W, either clamping or keeping the low bits
    function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] ve;
        logic signed [EXT_W-1:0] vmax;
        logic signed [EXT_W-1:0] vmin;
        logic signed [OUT_W-1:0] omax;
        logic signed [OUT_W-1:0] omin;
        omax = {1'b0, {(OUT_W-1){1'b1}}};
        omin = {1'b1, {(OUT_W-1){1'b0}}};
        ve   = EXT_W'(v);
        vmax = EXT_W'(omax);
        vmin = EXT_W'(omin);
        if ((SATURATE != 0) && (ve > vmax)) begin
            return omax;
        end
        if ((SATURATE != 0) && (ve < vmin)) begin
            return omin;
        end
        return ve[OUT_W-1:0];
    endfunction

    // Lane datapath: lane l works on row pass*LANES+l; column 0 restarts the sum
    always_comb begin
        int row;
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] x_ext;
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  prod_ext;
        logic signed [ACC_W-1:0]  sum;
        acc_d = acc_q;
        y_we  = (state_q == S_COMPUTE) && !fin_q && (col_q == CW'(COLS - 1));
        for (int l = 0; l < LANES; l++) begin
            row      = int'(pass_q) * LANES + l;
            a_ext    = PROD_W'(a_mem_q[AW'(row * COLS + int'(col_q))]);
            x_ext    = PROD_W'(x_mem_q[col_q]);
            prod     = a_ext * x_ext;
            prod_ext = ACC_W'(prod);
            if (col_q == '0) begin
                sum = prod_ext;
            end else begin
                sum = $signed(acc_q[l]) + prod_ext;
            end
            if ((state_q == S_COMPUTE) && !fin_q) begin
                acc_d[l] = sum;
            end
            y_waddr[l] = RW'(row);
            y_wdata[l] = narrow(sum);
        end
    end

    // Command sequencing, load indexing, compute stepping and output handshake
    always_comb begin
        state_d     = state_q;
        ld_idx_d    = ld_idx_q;
        col_d       = col_q;
        pass_d      = pass_q;
        fin_d       = fin_q;
        oidx_d      = oidx_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        a_we        = 1'b0;
        x_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (loadMatrix) begin
                    state_d  = S_LOAD_A;
                    ld_idx_d = '0;
                end else if (loadVector) begin
                    state_d  = S_LOAD_X;
                    ld_idx_d = '0;
                end else if (start) begin
                    state_d = S_COMPUTE;
                    col_d   = '0;
                    pass_d  = '0;
                    fin_d   = 1'b0;
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    a_we = 1'b1;
                    if (ld_idx_q == AW'(NA - 1)) begin
                        state_d  = S_IDLE;
                        ld_idx_d = '0;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            S_LOAD_X: begin
                if (in_valid) begin
                    x_we = 1'b1;
                    if (ld_idx_q == AW'(COLS - 1)) begin
                        state_d  = S_IDLE;
                        ld_idx_d = '0;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (fin_q) begin
                    // Last pass has been written to the result buffer; present y[0]
                    fin_d       = 1'b0;
                    state_d     = S_OUTPUT;
                    done_d      = 1'b1;
                    out_valid_d = 1'b1;
                    data_out_d  = y_mem_q[RW'(0)];
                    oidx_d      = '0;
                end else if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    if (pass_q == PW'(PASSES - 1)) begin
                        pass_d = '0;
                        fin_d  = 1'b1;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (oidx_q == RW'(ROWS - 1)) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        data_out_d  = '0;
                        oidx_d      = '0;
                    end else begin
                        oidx_d     = oidx_q + 1'b1;
                        data_out_d = y_mem_q[oidx_q + 1'b1];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ld_idx_q    <= '0;
            col_q       <= '0;
            pass_q      <= '0;
            fin_q       <= 1'b0;
            oidx_q      <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            ld_idx_q    <= ld_idx_d;
            col_q       <= col_d;
            pass_q      <= pass_d;
            fin_q       <= fin_d;
            oidx_q      <= oidx_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            acc_q       <= acc_d;
        end
    end

    // Storage writes: matrix and vector words during loads, lane results at each pass end
    always_ff @(posedge clk) begin
        if (a_we) begin
            a_mem_q[ld_idx_q] <= data_in;
        end
        if (x_we) begin
            x_mem_q[ld_idx_q[CW-1:0]] <= data_in;
        end
        if (y_we) begin
            for (int l = 0; l < LANES; l++) begin
                y_mem_q[y_waddr[l]] <= y_wdata[l];
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_mvm_param.sv
// tb/tb_mvm_param.sv - self-checking bench for mvm_param (wrap and saturate instances side by side)
module tb_mvm_param;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int L  = 2;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int NT = 6;

    logic          clk;
    logic          reset;
    logic          loadMatrix;
    logic          loadVector;
    logic          start;
    logic          in_valid;
    logic [IW-1:0] data_in;
    logic          out_ready;
    logic          busy_w, done_w, out_valid_w;
    logic          busy_s, done_s, out_valid_s;
    logic [OW-1:0] data_out_w, data_out_s;

    int total = 0;
    int bad   = 0;
    int low_busy;
    int ma [R][C];
    int mx [C];

    typedef struct {
        int               akind;
        int               aval;
        int               gap;
        int               mode;
        bit               poke;
        logic [3:0][15:0] x;
        logic [3:0][15:0] ew;
        logic [3:0][15:0] es;
    } vec_t;

    vec_t tbl [NT];

    mvm_param #(.ROWS(R), .COLS(C), .LANES(L), .IN_W(IW), .OUT_W(OW), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .in_valid(in_valid), .data_in(data_in), .busy(busy_w), .done(done_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .data_out(data_out_w)
    );

    mvm_param #(.ROWS(R), .COLS(C), .LANES(L), .IN_W(IW), .OUT_W(OW), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .in_valid(in_valid), .data_in(data_in), .busy(busy_s), .done(done_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .data_out(data_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][15:0] v4(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] r;
        r[0] = a[15:0];
        r[1] = b[15:0];
        r[2] = c[15:0];
        r[3] = d[15:0];
        return r;
    endfunction

    function automatic int narrow_ref(input longint v, input bit sat);
        longint m;
        longint span;
        span = longint'(1) << OW;
        if (sat) begin
            if (v > (span / 2 - 1)) return int'(span / 2 - 1);
            if (v < -(span / 2)) return int'(-(span / 2));
            return int'(v);
        end
        m = v % span;
        if (m < 0) m = m + span;
        if (m >= span / 2) m = m - span;
        return int'(m);
    endfunction

    task automatic model_y(output int ew [4], output int es [4]);
        longint s;
        for (int r = 0; r < R; r++) begin
            s = 0;
            for (int c = 0; c < C; c++) begin
                s = s + longint'(ma[r][c]) * longint'(mx[c]);
            end
            ew[r] = narrow_ref(s, 1'b0);
            es[r] = narrow_ref(s, 1'b1);
        end
    endtask

    task automatic set_a(input int kind, input int val);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (kind == 0) ma[r][c] = (r == c) ? 1 : 0;
                else if (kind == 1) ma[r][c] = val;
                else ma[r][c] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    task automatic send_word(input int v, input int ngap);
        repeat (ngap) begin
            in_valid = 1'b0;
            data_in  = IW'($urandom);
            @(negedge clk);
            if (!busy_w || !busy_s) low_busy++;
        end
        in_valid = 1'b1;
        data_in  = IW'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_matrix(input int gap);
        low_busy   = 0;
        loadMatrix = 1'b1;
        @(negedge clk);
        loadMatrix = 1'b0;
        if (!busy_w || !busy_s) low_busy++;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                send_word(ma[r][c], (gap != 0) ? int'($urandom_range(0, 2)) : 0);
                if (!((r == R - 1) && (c == C - 1)) && (!busy_w || !busy_s)) low_busy++;
            end
        end
        check("a_load_busy_high", low_busy, 0);
        check("a_load_busy_end", int'(busy_w) + int'(busy_s), 0);
    endtask

    task automatic load_vector(input int gap, input bit with_start);
        low_busy   = 0;
        loadVector = 1'b1;
        start      = with_start;
        @(negedge clk);
        loadVector = 1'b0;
        start      = 1'b0;
        if (!busy_w || !busy_s) low_busy++;
        for (int c = 0; c < C; c++) begin
            send_word(mx[c], ((gap != 0) && (c > 0)) ? 2 : 0);
            if ((c != C - 1) && (!busy_w || !busy_s)) low_busy++;
        end
        check("x_load_busy_high", low_busy, 0);
        check("x_load_busy_end", int'(busy_w) + int'(busy_s), 0);
    endtask

    // mode 0: always ready; 1: 3-cycle stall then 1/0 toggle; 2: random ready
    task automatic run_compute(input string nm, input int mode, input bit poke,
                               input int ew [4], input int es [4]);
        int lat;
        int n;
        int cyc;
        int hold_bad;
        int gw [4];
        int gs [4];
        for (int i = 0; i < 4; i++) begin
            gw[i] = 0;
            gs[i] = 0;
        end
        hold_bad  = 0;
        out_ready = (mode == 1) ? 1'b0 : 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done_w && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, lat, (R / L) * C + 1);
        check({nm, "_done_sync"}, int'(done_s), 1);
        check({nm, "_valid_on_done"}, int'(out_valid_w), 1);
        n   = 0;
        cyc = 0;
        while (n < R && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc >= 3) && (((cyc - 3) % 2) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            loadMatrix = poke && (cyc == 1);
            if ((mode == 1) && (cyc < 3)) begin
                if (!out_valid_w || (int'($signed(data_out_w)) != ew[0])) hold_bad++;
            end
            if (out_valid_w && out_ready) begin
                gw[n] = int'($signed(data_out_w));
                gs[n] = int'($signed(data_out_s));
                n++;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({nm, "_done_pulse"}, int'(done_w), 0);
        end
        loadMatrix = 1'b0;
        out_ready  = 1'b1;
        if (mode == 1) check({nm, "_stall_hold"}, hold_bad, 0);
        check({nm, "_words"}, n, R);
        check({nm, "_busy_end"}, int'(busy_w) + int'(busy_s), 0);
        check({nm, "_valid_end"}, int'(out_valid_w) + int'(out_valid_s), 0);
        check({nm, "_data_end"}, int'(data_out_w) + int'(data_out_s), 0);
        for (int r = 0; r < R; r++) begin
            check($sformatf("%s_wrap_y%0d", nm, r), gw[r], ew[r]);
            check($sformatf("%s_sat_y%0d", nm, r), gs[r], es[r]);
        end
    endtask

    task automatic async_reset_check(input string nm);
        #2;
        reset = 1'b0;
        #1;
        check({nm, "_busy"}, int'(busy_w) + int'(busy_s), 0);
        check({nm, "_valid"}, int'(out_valid_w) + int'(out_valid_s), 0);
        check({nm, "_data"}, int'(data_out_w) + int'(data_out_s), 0);
        check({nm, "_done"}, int'(done_w) + int'(done_s), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int ew [4];
        int es [4];
        int dn;
        int lat;

        tbl[0] = '{0, 0, 0, 0, 1'b0, v4(1, -2, 3, -4), v4(1, -2, 3, -4), v4(1, -2, 3, -4)};
        tbl[1] = '{1, 127, 0, 0, 1'b0, v4(127, 127, 127, 127),
                   v4(-1020, -1020, -1020, -1020), v4(32767, 32767, 32767, 32767)};
        tbl[2] = '{1, -128, 0, 0, 1'b0, v4(-128, -128, -128, -128),
                   v4(0, 0, 0, 0), v4(32767, 32767, 32767, 32767)};
        tbl[3] = '{0, 0, 0, 1, 1'b1, v4(5, 6, 7, 8), v4(5, 6, 7, 8), v4(5, 6, 7, 8)};
        tbl[4] = '{0, 0, 1, 0, 1'b0, v4(1, -2, 3, -4), v4(1, -2, 3, -4), v4(1, -2, 3, -4)};
        tbl[5] = '{1, 127, 0, 2, 1'b0, v4(-128, -128, -128, -128),
                   v4(512, 512, 512, 512), v4(-32768, -32768, -32768, -32768)};

        reset      = 1'b0;
        loadMatrix = 1'b0;
        loadVector = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        data_in    = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_w) + int'(busy_s), 0);
        check("rst_done", int'(done_w) + int'(done_s), 0);
        check("rst_valid", int'(out_valid_w) + int'(out_valid_s), 0);
        check("rst_data", int'(data_out_w) + int'(data_out_s), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NT; i++) begin
            set_a(tbl[i].akind, tbl[i].aval);
            for (int c = 0; c < C; c++) mx[c] = int'($signed(tbl[i].x[c]));
            for (int r = 0; r < R; r++) begin
                ew[r] = int'($signed(tbl[i].ew[r]));
                es[r] = int'($signed(tbl[i].es[r]));
            end
            load_matrix(tbl[i].gap);
            load_vector(tbl[i].gap, 1'b0);
            run_compute($sformatf("vec%0d", i), tbl[i].mode, tbl[i].poke, ew, es);
        end

        // Second start with no reload must reproduce the same words
        run_compute("restart", 0, 1'b0, ew, es);

        // Randomised operands; odd iterations reload only x and reuse A
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) begin
                set_a(2, 0);
                load_matrix(1);
            end
            for (int c = 0; c < C; c++) mx[c] = int'($urandom_range(0, 255)) - 128;
            load_vector(k % 2, 1'b0);
            model_y(ew, es);
            run_compute($sformatf("rnd%0d", k), 2, 1'b0, ew, es);
        end

        // loadVector together with start: vector load wins, nothing computed
        for (int c = 0; c < C; c++) mx[c] = int'($urandom_range(0, 255)) - 128;
        load_vector(0, 1'b1);
        dn = 0;
        repeat (14) begin
            @(negedge clk);
            if (done_w || out_valid_w || busy_w) dn++;
        end
        check("lv_start_no_compute", dn, 0);
        model_y(ew, es);
        run_compute("after_lv", 0, 1'b0, ew, es);

        // Reset while y[0] is stalled at the output
        out_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done_w && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("stall_pre_reset_valid", int'(out_valid_w), 1);
        async_reset_check("rst_output");
        out_ready = 1'b1;

        // Reset two cycles into COMPUTE, then a clean reload and run
        set_a(2, 0);
        load_matrix(0);
        for (int c = 0; c < C; c++) mx[c] = int'($urandom_range(0, 255)) - 128;
        load_vector(0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_compute_busy", int'(busy_w), 1);
        async_reset_check("rst_compute");
        set_a(2, 0);
        load_matrix(1);
        for (int c = 0; c < C; c++) mx[c] = int'($urandom_range(0, 255)) - 128;
        load_vector(1, 1'b0);
        model_y(ew, es);
        run_compute("post_reset", 0, 1'b0, ew, es);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mvm_param.md
Name: mvm_param

Overview:
- Parametrised matrix-vector multiplier, y = A·x, with a rectangular ROWS×COLS matrix, LANES parallel MAC lanes and a selectable saturate/wrap output mode.
- Adds input-side stalls (in_valid) and output backpressure (out_valid/out_ready) to the existing command protocol: loadMatrix/loadVector/start pulses, serial data_in, serial data_out.
- Sits between the serial sample stream and downstream consumers that may stall.

Parameters:
ROWS, 8, matrix rows and output vector length
COLS, 8, matrix columns and input vector length
LANES, 1, parallel MAC lanes; must divide ROWS
IN_W, 16, signed input word width
OUT_W, 32, signed output word width
SATURATE, 0, 1 clamps results to the OUT_W signed range; 0 wraps (keeps the low OUT_W bits)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
loadMatrix  input  1  command pulse: load A
loadVector  input  1  command pulse: load x
start  input  1  command pulse: compute y
in_valid  input  1  data_in word qualifier during loads
data_in  input  IN_W  signed matrix/vector word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when y[0] is first presented
out_valid  output  1  data_out holds a valid y word
out_ready  input  1  consumer accepts data_out
data_out  output  OUT_W  signed result word

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, data_out=0, state=IDLE. A and x storage is not reset; its contents are unspecified until loaded.
- Reset low in any state aborts the current operation immediately (asynchronous). The partial load or result is discarded.
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
- Command sampling: commands are sampled only in IDLE. Priority is loadMatrix > loadVector > start. Commands seen in any other state are ignored.
- LOAD_A:
  - Entered on the edge after loadMatrix is sampled.
  - Accepts ROWS·COLS words in row-major order, one per edge on which in_valid=1.
  - Returns to IDLE on the edge that accepts the last word.
- LOAD_X: same as LOAD_A, for COLS words.
- COMPUTE:
  - Entered on the edge after start is sampled.
  - Runs ROWS/LANES passes of COLS cycles each. In each pass, lane l accumulates row p·LANES+l.
  - Accumulators are full precision, 2·IN_W+clog2(COLS) bits. Every product is sign-extended before addition.
  - Total COMPUTE duration is (ROWS/LANES)·COLS cycles. The lane results are then latched into a ROWS-deep output buffer.
- OUTPUT:
  - Entered one cycle after the last accumulation.
  - On entry, done=1 for exactly one cycle, out_valid=1, and data_out=y[0].
  - The word index advances on each edge where out_valid & out_ready. While out_ready=0, data_out holds its value and out_valid stays high.
  - After y[ROWS-1] is accepted: out_valid=0, data_out=0, and the state returns to IDLE on that same edge.
- Latency: start is sampled on edge N; done and out_valid rise after edge N+(ROWS/LANES)·COLS+1.
- Narrowing to OUT_W:
  - SATURATE=1: values above 2^(OUT_W-1)-1 clamp to that value; values below -2^(OUT_W-1) clamp to -2^(OUT_W-1).
  - SATURATE=0: take the low OUT_W bits, two's complement.
- start with no prior load after reset: protocol and timing are unchanged; the values of data_out are unspecified.
- A and x are retained across operations. A start may reuse earlier loads. Reloading only x is legal.

Test Plan:
Common configuration unless noted: ROWS=4, COLS=4, LANES=2, IN_W=8, OUT_W=16.
1. Identity A; x=[1,-2,3,-4]; start; out_ready=1 -> done rises 9 cycles after the start edge; y=[1,-2,3,-4]; busy falls after the 4th word.
2. A all 127, x all 127, SATURATE=1 -> every y=32767. Same stimulus with SATURATE=0 -> every y=-1020 (64516 mod 2^16). A and x all -128: SATURATE=1 -> 32767; SATURATE=0 -> 0.
3. Backpressure: A=identity, x=[5,6,7,8]; hold out_ready=0 for 3 cycles after done, then toggle it 1/0 -> data_out=5 holds with out_valid=1 throughout the stall; the outputs arrive exactly as 5,6,7,8 with no duplicates or drops.
4. Load stalls: load x with 2-cycle in_valid=0 gaps between words and A with random gaps -> results match scenario 1; busy stays high through each load.
5. Reset mid-COMPUTE (2 cycles after start) -> all outputs 0 asynchronously and busy=0. Then reload A and x and start -> correct y, no residue from the aborted run.
6. Command arbitration:
   - loadVector and start high together in IDLE -> a vector load occurs and no compute.
   - loadMatrix pulsed during OUTPUT -> ignored; the remaining y words are unchanged.
   - start issued twice in a row with no reload -> identical outputs both times.
